config_chain_loader: RTL and testbench

// Host-side driver for the serial configuration chain (config_in/config_en/config_out) threaded through slices.

---
 rtl/config_chain_loader_pkg.sv | 13 +
 rtl/config_chain_loader_rb_collector.sv | 50 +++++
 rtl/config_chain_loader.sv | 96 +++++++++
 tb/tb_config_chain_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/config_chain_loader_pkg.sv
// config_chain_loader_pkg: shared FSM encodings and sizing helpers for configuration chain tools
package config_chain_loader_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/config_chain_loader_rb_collector.sv
// config_chain_loader_rb_collector: deserialises chain readback bits into MSB-first words behind a valid/ready hold register
module config_chain_loader_rb_collector
   import config_chain_loader_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic              config_clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              bit_in,
   input  logic              flush,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              stall,
   output logic              empty
);
   localparam int CW = cnt_w(WORD_W);
   logic [WORD_W-1:0] acc;
   logic [CW-1:0]     acc_cnt;
   logic              full, hold_free, mv;
   assign full      = acc_cnt == CW'(WORD_W);
   assign hold_free = !rb_valid || rb_ready;
   assign mv        = (full || (flush && acc_cnt != '0)) && hold_free;
   assign stall     = full && !hold_free;
   assign empty     = acc_cnt == '0;
   // collect bits, hand complete (or left-aligned final partial) words to the hold register
   always_ff @(posedge config_clk) begin
      if (rst) begin
         acc      <= '0;
         acc_cnt  <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         if (mv) begin
            rb_data  <= acc << (CW'(WORD_W) - acc_cnt);
            rb_valid <= 1'b1;
         end else if (rb_ready) begin
            rb_valid <= 1'b0;
         end
         if (mv) begin
            acc     <= {{(WORD_W-1){1'b0}}, bit_in & bit_en};
            acc_cnt <= {{(CW-1){1'b0}}, bit_en};
         end else if (bit_en) begin
            acc     <= {acc[WORD_W-2:0], bit_in};
            acc_cnt <= acc_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: streams configuration words MSB-first into a serial chain and returns the displaced contents
module config_chain_loader
   import config_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 256,
   parameter int WORD_W    = 32
) (
   input  logic              config_clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              config_in,
   output logic              config_en,
   input  logic              config_out,
   output logic [WORD_W-1:0] rb_data,
   output logic              rb_valid,
   input  logic              rb_ready,
   output logic              busy,
   output logic              done
);
   localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
   localparam int BCW    = cnt_w(CHAIN_LEN);
   localparam int WCW    = cnt_w(NWORDS);
   localparam int SCW    = cnt_w(WORD_W);
   logic [1:0]        state;
   logic [WORD_W-1:0] sh_reg, buf_reg;
   logic [SCW-1:0]    sh_cnt;
   logic              buf_full;
   logic [BCW-1:0]    bit_cnt;
   logic [WCW-1:0]    words_acc;
   logic              shifting, stall, col_empty, hs, sh_free, last_bit, start_ok;
   assign shifting  = state == ST_SHIFT;
   assign config_en = shifting && sh_cnt != '0 && !stall && !rst;
   assign config_in = config_en & sh_reg[WORD_W-1];
   assign s_ready   = shifting && !buf_full && words_acc < WCW'(NWORDS);
   assign hs        = s_valid && s_ready;
   assign sh_free   = sh_cnt == '0 || (config_en && sh_cnt == SCW'(1));
   assign last_bit  = config_en && bit_cnt == BCW'(CHAIN_LEN - 1);
   assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);
   assign busy      = shifting || state == ST_FLUSH;
   assign done      = state == ST_DONE;
   // load sequencing and the bit/word progress counters
   always_ff @(posedge config_clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         words_acc <= '0;
      end else if (start_ok) begin
         state     <= ST_SHIFT;
         bit_cnt   <= '0;
         words_acc <= '0;
      end else begin
         if (last_bit) state <= ST_FLUSH;
         else if (state == ST_FLUSH && col_empty && rb_valid && rb_ready) state <= ST_DONE;
         if (config_en) bit_cnt <= bit_cnt + 1'b1;
         if (hs) words_acc <= words_acc + 1'b1;
      end
   end
   // output shift register fed directly or from the one-word prefetch buffer; leftover bits are dropped at the end
   always_ff @(posedge config_clk) begin
      if (rst || start_ok || last_bit) begin
         sh_cnt   <= '0;
         buf_full <= 1'b0;
      end else begin
         if (config_en) begin
            sh_reg <= {sh_reg[WORD_W-2:0], 1'b0};
            sh_cnt <= sh_cnt - 1'b1;
         end
         if (sh_free && buf_full) begin
            sh_reg   <= buf_reg;
            sh_cnt   <= SCW'(WORD_W);
            buf_full <= 1'b0;
         end else if (sh_free && hs) begin
            sh_reg <= s_data;
            sh_cnt <= SCW'(WORD_W);
         end else if (hs) begin
            buf_full <= 1'b1;
         end
         if (hs) buf_reg <= s_data;
      end
   end
   config_chain_loader_rb_collector #(.WORD_W(WORD_W)) u_rb (
      .config_clk (config_clk),
      .rst        (rst),
      .bit_en     (config_en),
      .bit_in     (config_out),
      .flush      (state == ST_FLUSH),
      .rb_data    (rb_data),
      .rb_valid   (rb_valid),
      .rb_ready   (rb_ready),
      .stall      (stall),
      .empty      (col_empty)
   );
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: two loaders (16-bit and 20-bit chains) with behavioural chains and a readback scoreboard
module tb_config_chain_loader;
   localparam int W = 8;
   logic          config_clk = 1'b0;
   logic          rst = 1'b1, start_a = 1'b0, start_b = 1'b0, s_valid = 1'b0, rb_ready = 1'b1, sel = 1'b0;
   logic [W-1:0]  s_data = '0;
   logic          s_ready_a, s_ready_b, in_a, in_b, en_a, en_b, rbv_a, rbv_b, busy_a, busy_b, done_a, done_b;
   logic [W-1:0]  rbd_a, rbd_b;
   logic [15:0]   chain_a = '0, preset_a = '0;
   logic [19:0]   chain_b = '0, preset_b = '0;
   logic          load_pre = 1'b0;
   logic          s_ready, cfg_en, cfg_in, rb_valid, busy, done;
   logic [W-1:0]  rb_data;
   logic [W-1:0]  exp_q[$];
   int            checks = 0, failures = 0, en_cnt = 0, run = 0, max_run = 0;

   always #5 config_clk = ~config_clk;

   assign s_ready  = sel ? s_ready_b : s_ready_a;
   assign cfg_en   = sel ? en_b : en_a;
   assign cfg_in   = sel ? in_b : in_a;
   assign rb_valid = sel ? rbv_b : rbv_a;
   assign rb_data  = sel ? rbd_b : rbd_a;
   assign busy     = sel ? busy_b : busy_a;
   assign done     = sel ? done_b : done_a;

   config_chain_loader #(.CHAIN_LEN(16), .WORD_W(W)) dut_a (
      .config_clk(config_clk), .rst(rst), .start(start_a), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready_a), .config_in(in_a), .config_en(en_a), .config_out(chain_a[15]),
      .rb_data(rbd_a), .rb_valid(rbv_a), .rb_ready(rb_ready), .busy(busy_a), .done(done_a));
   config_chain_loader #(.CHAIN_LEN(20), .WORD_W(W)) dut_b (
      .config_clk(config_clk), .rst(rst), .start(start_b), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready_b), .config_in(in_b), .config_en(en_b), .config_out(chain_b[19]),
      .rb_data(rbd_b), .rb_valid(rbv_b), .rb_ready(rb_ready), .busy(busy_b), .done(done_b));

   always @(posedge config_clk) begin
      if (load_pre) begin
         chain_a <= preset_a;
         chain_b <= preset_b;
      end else begin
         if (en_a) chain_a <= {chain_a[14:0], in_a};
         if (en_b) chain_b <= {chain_b[18:0], in_b};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge config_clk) begin
      if (cfg_en) begin
         en_cnt++;
         run++;
         if (run > max_run) max_run = run;
      end else run = 0;
      if (rb_valid && rb_ready) begin
         if (exp_q.size() == 0) check("rb_unexpected", 32'(rb_data), 32'hDEAD);
         else check("rb_word", 32'(rb_data), 32'(exp_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge config_clk);
      #1;
   endtask

   task automatic pulse_start();
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && n < 200) begin
         tick();
         n++;
      end
      if (!s_ready) check("push_timeout", 32'(s_ready), 32'h1);
      tick();
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 300) begin
         tick();
         n++;
      end
      check("done", 32'(done), 32'h1);
   endtask

   task automatic begin_test(input logic s);
      sel     = s;
      en_cnt  = 0;
      max_run = 0;
   endtask

   initial begin
      preset_a = 16'hA5C3;
      preset_b = 20'h5A3C9;
      load_pre = 1'b1;
      tick();
      load_pre = 1'b0;
      tick();
      rst = 1'b0;
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_config_en", 32'(cfg_en), 0);
      check("rst_config_in", 32'(cfg_in), 0);
      check("rst_rb_valid", 32'(rb_valid), 0);
      check("rst_rb_data", 32'(rb_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);

      begin_test(1'b0);
      s_valid = 1'b1;
      s_data  = 8'hFF;
      repeat (4) tick();
      check("idle_s_ready", 32'(s_ready), 0);
      s_valid = 1'b0;
      check("idle_en_cnt", 32'(en_cnt), 0);
      check("idle_chain", 32'(chain_a), 32'hA5C3);

      begin_test(1'b0);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'hC3);
      pulse_start();
      check("start_busy", 32'(busy), 1);
      check("start_s_ready", 32'(s_ready), 1);
      push_word(8'h12);
      push_word(8'h34);
      s_valid = 1'b0;
      wait_done();
      check("l16_chain", 32'(chain_a), 32'h1234);
      check("l16_en_cnt", 32'(en_cnt), 16);
      check("l16_no_bubble", 32'(max_run), 16);
      check("l16_busy", 32'(busy), 0);
      check("l16_s_ready", 32'(s_ready), 0);

      begin_test(1'b1);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h90);
      pulse_start();
      push_word(8'hFF);
      push_word(8'h00);
      push_word(8'hB7);
      s_valid = 1'b0;
      wait_done();
      check("l20_chain", 32'(chain_b), 32'hFF00B);
      check("l20_en_cnt", 32'(en_cnt), 20);

      begin_test(1'b1);
      rb_ready = 1'b0;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hB0);
      pulse_start();
      push_word(8'h3C);
      push_word(8'h96);
      push_word(8'h5A);
      s_valid = 1'b0;
      repeat (12) tick();
      check("stall_en_cnt", 32'(en_cnt), 16);
      check("stall_config_en", 32'(cfg_en), 0);
      check("stall_rb_valid", 32'(rb_valid), 1);
      check("stall_busy", 32'(busy), 1);
      rb_ready = 1'b1;
      wait_done();
      check("stall_chain", 32'(chain_b), 32'h3C965);
      check("stall_en_total", 32'(en_cnt), 20);

      begin_test(1'b0);
      pulse_start();
      push_word(8'hF0);
      s_valid = 1'b0;
      for (int n = 0; n < 50 && en_cnt < 5; n++) tick();
      rst = 1'b1;
      tick();
      check("mid_rst_config_en", 32'(cfg_en), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_rb_valid", 32'(rb_valid), 0);
      check("mid_rst_s_ready", 32'(s_ready), 0);
      rst = 1'b0;
      tick();
      check("mid_rst_en_cnt", 32'(en_cnt), 5);
      check("mid_rst_chain", 32'(chain_a), 32'h469E);
      begin_test(1'b0);
      exp_q.push_back(8'h46);
      exp_q.push_back(8'h9E);
      pulse_start();
      push_word(8'hAB);
      push_word(8'hCD);
      s_valid = 1'b0;
      wait_done();
      check("post_rst_chain", 32'(chain_a), 32'hABCD);
      check("post_rst_en_cnt", 32'(en_cnt), 16);

      begin_test(1'b0);
      exp_q.push_back(8'hAB);
      exp_q.push_back(8'hCD);
      pulse_start();
      push_word(8'h55);
      s_valid = 1'b0;
      repeat (3) tick();
      pulse_start();
      repeat (8) tick();
      check("starve_en_cnt", 32'(en_cnt), 8);
      check("starve_config_en", 32'(cfg_en), 0);
      check("starve_busy", 32'(busy), 1);
      push_word(8'hAA);
      s_valid = 1'b0;
      wait_done();
      check("busy_start_chain", 32'(chain_a), 32'h55AA);
      check("busy_start_en_cnt", 32'(en_cnt), 16);

      repeat (3) tick();
      check("rb_queue_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
